mdu_arb: RTL and testbench

- Round-robin arbiter and sequencer that shares one iterative multiply/divide unit (MDU) among N requesters such as CPUs or DMA.
- Sits between the requesters and a shared mul/div datapath in the fast clock domain.
- Latches the winning requester's operands, issues a start pulse and waits for the unit's done.
- Returns the result on a shared bus with a one-cycle ack to the owner.

---
 rtl/mdu_arb.sv | 104 ++++++++++
 tb/tb_mdu_arb.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mdu_arb.sv
// mdu_arb: round-robin arbiter/sequencer sharing one iterative mul/div unit among N requesters.
// Define MDU_ARB_TIMEOUT_EN to bound WAIT to TMO cycles and flag expiry on err.
module mdu_arb #(
  parameter int N   = 4,
  parameter int W   = 32,
  parameter int TMO = 255
) (
  input  logic           clk,
  input  logic           rstb,
  input  logic [N-1:0]   req,
  input  logic [N-1:0]   sel,
  input  logic [N*W-1:0] a,
  input  logic [N*W-1:0] b,
  output logic [N-1:0]   ack,
  output logic [N-1:0]   err,
  output logic [2*W-1:0] res,
  output logic [N-1:0]   gnt,
  output logic           u_start,
  output logic           u_sel,
  output logic [W-1:0]   u_a,
  output logic [W-1:0]   u_b,
  input  logic           u_done,
  input  logic [2*W-1:0] u_res
);
  localparam int IW = $clog2(N);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, own, win;
  logic w_sel;
  logic [W-1:0] w_a, w_b;
  logic tmo;
  // Pass 0 finds the lowest request at or below ptr, pass 1 overrides it with the lowest above ptr.
  always_comb begin
    win = '0;
    w_sel = 1'b0;
    w_a = '0;
    w_b = '0;
    for (int p = 0; p < 2; p++)
      for (int k = N - 1; k >= 0; k--)
        if (req[k] && ((p == 1) == (IW'(k) > ptr))) begin
          win = IW'(k);
          w_sel = sel[k];
          w_a = a[k*W +: W];
          w_b = b[k*W +: W];
        end
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = |req ? ISSUE : IDLE;
      ISSUE:   state_nx = WAIT;
      WAIT:    state_nx = (u_done || tmo) ? RESP : WAIT;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      ptr <= IW'(N - 1);
      own <= '0;
      gnt <= '0;
      ack <= '0;
      res <= '0;
      u_start <= 1'b0;
      u_sel <= 1'b0;
      u_a <= '0;
      u_b <= '0;
    end else begin
      u_start <= state == IDLE && |req;
      ack <= (state == WAIT && (u_done || tmo)) ? gnt : '0;
      if (state == IDLE && |req) begin
        own <= win;
        gnt <= N'(1) << win;
        u_sel <= w_sel;
        u_a <= w_a;
        u_b <= w_b;
      end
      if (state == WAIT && u_done) res <= u_res;
      else if (tmo) res <= '0;
      if (state == RESP) begin
        ptr <= own;
        gnt <= '0;
      end
    end
`ifdef MDU_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TMO + 1);
  logic [CW-1:0] cnt;
  // Fires on the cycle the counter would reach TMO; a same-cycle u_done takes priority.
  assign tmo = state == WAIT && !u_done && cnt == CW'(TMO - 1);
  always_ff @(posedge clk or negedge rstb)
    if (!rstb) begin
      cnt <= '0;
      err <= '0;
    end else begin
      cnt <= state == WAIT ? cnt + 1'b1 : '0;
      err <= tmo ? gnt : '0;
    end
`else
  assign tmo = 1'b0;
  assign err = '0;
`endif
endmodule

// File: tb/tb_mdu_arb.sv
// tb_mdu_arb: directed self-checking bench for mdu_arb with a behavioural mul/div unit.
module tb_mdu_arb;
  localparam int N = 4;
  localparam int W = 32;
  logic clk = 1'b0;
  logic rstb;
  logic [N-1:0] req, sel, ack, err, gnt;
  logic [N*W-1:0] a, b;
  logic [2*W-1:0] res, u_res, m_res, x_res;
  logic u_start, u_sel, u_done, m_done, x_done;
  logic [W-1:0] u_a, u_b;
  logic mdu_en = 1'b1;
  int mdu_lat = 1;
  int checks = 0;
  int failures = 0;
  mdu_arb #(.N(N), .W(W), .TMO(255)) dut (
    .clk(clk), .rstb(rstb), .req(req), .sel(sel), .a(a), .b(b),
    .ack(ack), .err(err), .res(res), .gnt(gnt),
    .u_start(u_start), .u_sel(u_sel), .u_a(u_a), .u_b(u_b),
    .u_done(u_done), .u_res(u_res)
  );
  always #5 clk = ~clk;
  assign u_done = m_done | x_done;
  assign u_res = x_done ? x_res : m_res;
  // Behavioural MDU: answers mdu_lat cycles after it sees u_start.
  initial begin
    m_done = 1'b0;
    m_res = '0;
    forever begin
      @(posedge clk);
      if (u_start === 1'b1 && mdu_en) begin
        repeat (mdu_lat - 1) @(posedge clk);
        #1;
        m_done = 1'b1;
        m_res = u_sel ? {u_a % u_b, u_a / u_b} : {32'h0, u_a} * {32'h0, u_b};
        @(posedge clk);
        #1 m_done = 1'b0;
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ack(input int budget, output logic [N-1:0] seen, output int cyc);
    cyc = 0;
    while (ack == '0 && cyc < budget) begin
      tick();
      cyc++;
    end
    seen = ack;
  endtask
  task automatic do_reset;
    rstb = 1'b0;
    req = '0;
    tick();
    tick();
    rstb = 1'b1;
    tick();
  endtask
  task automatic test_reset;
    rstb = 1'b0;
    req = '0;
    tick();
    tick();
    checks++; if (gnt !== '0) begin failures++; $display("FAIL reset_gnt got=%b exp=0000", gnt); end
    checks++; if (ack !== '0 || err !== '0) begin failures++; $display("FAIL reset_ack_err got=%b/%b exp=0000/0000", ack, err); end
    checks++; if (res !== '0) begin failures++; $display("FAIL reset_res got=%h exp=0", res); end
    checks++; if ({u_start, u_sel, u_a, u_b} !== '0) begin failures++; $display("FAIL reset_unit got=%b %b %h %h exp=all 0", u_start, u_sel, u_a, u_b); end
    rstb = 1'b1;
    tick();
    tick();
    checks++; if (gnt !== '0 || u_start !== 1'b0) begin failures++; $display("FAIL reset_idle got=%b/%b exp=0000/0", gnt, u_start); end
  endtask
  task automatic test_single;
    sel = '0;
    a[0 +: W] = 32'd7;
    b[0 +: W] = 32'd9;
    req = 4'b0001;
    tick();
    checks++; if (u_start !== 1'b1 || gnt !== 4'b0001) begin failures++; $display("FAIL single_issue got=%b/%b exp=1/0001", u_start, gnt); end
    checks++; if (u_a !== 32'd7 || u_b !== 32'd9 || u_sel !== 1'b0) begin failures++; $display("FAIL single_ops got=%0d/%0d/%b exp=7/9/0", u_a, u_b, u_sel); end
    tick();
    checks++; if (u_start !== 1'b0 || ack !== '0) begin failures++; $display("FAIL single_wait got=%b/%b exp=0/0000", u_start, ack); end
    tick();
    checks++; if (ack !== 4'b0001 || err !== '0) begin failures++; $display("FAIL single_ack got=%b/%b exp=0001/0000", ack, err); end
    checks++; if (res !== 64'd63) begin failures++; $display("FAIL single_res got=%0d exp=63", res); end
    req = '0;
    tick();
    checks++; if (ack !== '0 || gnt !== '0 || res !== 64'd63) begin failures++; $display("FAIL single_after got=%b/%b/%0d exp=0000/0000/63", ack, gnt, res); end
    tick();
    tick();
    checks++; if (gnt !== '0 || u_start !== 1'b0) begin failures++; $display("FAIL single_noregrant got=%b/%b exp=0000/0", gnt, u_start); end
  endtask
  task automatic test_fairness;
    logic [N-1:0] exp_g [5];
    logic [2*W-1:0] exp_r [5];
    logic [N-1:0] last;
    int ns, na;
    exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    exp_r = '{64'd10, 64'd20, 64'd30, 64'd40, 64'd10};
    do_reset();
    sel = '0;
    for (int k = 0; k < N; k++) begin
      a[k*W +: W] = 32'(k + 1);
      b[k*W +: W] = 32'd10;
    end
    ns = 0;
    na = 0;
    last = '0;
    req = 4'b1111;
    for (int c = 0; c < 60 && na < 5; c++) begin
      tick();
      if (u_start === 1'b1 && ns < 5) begin
        checks++; if (gnt !== exp_g[ns]) begin failures++; $display("FAIL fair_gnt%0d got=%b exp=%b", ns, gnt, exp_g[ns]); end
        last = gnt;
        ns++;
      end
      if (ack !== '0 && na < 5) begin
        checks++; if (ack !== last || res !== exp_r[na]) begin failures++; $display("FAIL fair_ack%0d got=%b/%0d exp=%b/%0d", na, ack, res, last, exp_r[na]); end
        na++;
      end
    end
    req = '0;
    checks++; if (ns !== 5 || na !== 5) begin failures++; $display("FAIL fair_count got=%0d/%0d exp=5/5", ns, na); end
    tick();
    tick();
  endtask
  task automatic test_isolation;
    logic [N-1:0] seen;
    int cyc, bad;
    mdu_lat = 3;
    sel = '0;
    a[2*W +: W] = 32'd5;
    b[2*W +: W] = 32'd3;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100 || u_a !== 32'd5) begin failures++; $display("FAIL iso_grant got=%b/%0d exp=0100/5", gnt, u_a); end
    a[2*W +: W] = 32'd6;
    bad = 0;
    cyc = 0;
    while (ack == '0 && cyc < 20) begin
      if (u_a !== 32'd5) bad++;
      tick();
      cyc++;
    end
    seen = ack;
    checks++; if (bad !== 0 || u_a !== 32'd5) begin failures++; $display("FAIL iso_hold got=%0d bad cycles u_a=%0d exp=0/5", bad, u_a); end
    checks++; if (seen !== 4'b0100 || res !== 64'd15) begin failures++; $display("FAIL iso_ack got=%b/%0d exp=0100/15", seen, res); end
    req = '0;
    mdu_lat = 1;
    tick();
    tick();
  endtask
  task automatic test_back_to_back;
    logic [N-1:0] seen;
    int cyc;
    do_reset();
    sel = 4'b1000;
    a[1*W +: W] = 32'd4;
    b[1*W +: W] = 32'd4;
    a[3*W +: W] = 32'd100;
    b[3*W +: W] = 32'd7;
    req = 4'b1010;
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL b2b_first got=%b exp=0010", gnt); end
    wait_ack(20, seen, cyc);
    checks++; if (seen !== 4'b0010 || res !== 64'd16) begin failures++; $display("FAIL b2b_ack1 got=%b/%0d exp=0010/16", seen, res); end
    req[1] = 1'b0;
    tick();
    req[1] = 1'b1;
    tick();
    checks++; if (u_start !== 1'b1 || gnt !== 4'b1000) begin failures++; $display("FAIL b2b_rotate got=%b/%b exp=1/1000", u_start, gnt); end
    wait_ack(20, seen, cyc);
    checks++; if (seen !== 4'b1000 || res !== {32'd2, 32'd14}) begin failures++; $display("FAIL b2b_div got=%b/%h exp=1000/%h", seen, res, {32'd2, 32'd14}); end
    req[3] = 1'b0;
    tick();
    tick();
    checks++; if (gnt !== 4'b0010) begin failures++; $display("FAIL b2b_third got=%b exp=0010", gnt); end
    wait_ack(20, seen, cyc);
    req = '0;
    tick();
    tick();
  endtask
  task automatic test_reset_mid;
    logic [N-1:0] seen;
    int cyc;
    mdu_en = 1'b0;
    sel = '0;
    a[0 +: W] = 32'd11;
    b[0 +: W] = 32'd3;
    req = 4'b0100;
    tick();
    checks++; if (gnt !== 4'b0100) begin failures++; $display("FAIL rmid_grant got=%b exp=0100", gnt); end
    tick();
    tick();
    tick();
    rstb = 1'b0;
    tick();
    checks++; if (gnt !== '0 || ack !== '0 || res !== '0 || u_a !== '0 || u_start !== 1'b0) begin failures++; $display("FAIL rmid_clear got=%b/%b/%h/%h/%b exp=all 0", gnt, ack, res, u_a, u_start); end
    tick();
    rstb = 1'b1;
    mdu_en = 1'b1;
    req = 4'b1111;
    tick();
    checks++; if (u_start !== 1'b1 || gnt !== 4'b0001) begin failures++; $display("FAIL rmid_first got=%b/%b exp=1/0001", u_start, gnt); end
    req = '0;
    wait_ack(20, seen, cyc);
    checks++; if (seen !== 4'b0001 || res !== 64'd33 || err !== '0) begin failures++; $display("FAIL rmid_dropreq got=%b/%0d/%b exp=0001/33/0000", seen, res, err); end
    tick();
    tick();
  endtask
`ifdef MDU_ARB_TIMEOUT_EN
  task automatic test_timeout;
    logic [N-1:0] seen;
    int cyc;
    mdu_en = 1'b0;
    req = 4'b0001;
    tick();
    checks++; if (u_start !== 1'b1) begin failures++; $display("FAIL tmo_start got=%b exp=1", u_start); end
    wait_ack(300, seen, cyc);
    checks++; if (cyc !== 256 || seen !== 4'b0001) begin failures++; $display("FAIL tmo_ack got=%0d cycles/%b exp=256/0001", cyc, seen); end
    checks++; if (err !== 4'b0001 || res !== '0) begin failures++; $display("FAIL tmo_err got=%b/%h exp=0001/0", err, res); end
    req = '0;
    tick();
    x_res = 64'hDEAD;
    x_done = 1'b1;
    tick();
    x_done = 1'b0;
    tick();
    checks++; if (ack !== '0 || err !== '0 || res !== '0 || gnt !== '0) begin failures++; $display("FAIL tmo_late got=%b/%b/%h/%b exp=all 0", ack, err, res, gnt); end
    mdu_en = 1'b1;
  endtask
`endif
  initial begin
    rstb = 1'b0;
    req = '0;
    sel = '0;
    a = '0;
    b = '0;
    x_done = 1'b0;
    x_res = '0;
    test_reset();
    test_single();
    test_fairness();
    test_isolation();
    test_back_to_back();
    test_reset_mid();
`ifdef MDU_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
